// File: rtl/x1_cpu_mem_arbiter_pkg.sv
// Shared types and constants for the X1 main-RAM arbiter.
package x1_mem_pkg;

  // Arbiter FSM states: one idle state plus one access state per requester.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DL_ACC  = 2'd1,
    VID_ACC = 2'd2,
    CPU_ACC = 2'd3
  } state_t;

  // Source of the most recent grant, used to let the CPU beat video after a video grant.
  typedef enum logic [1:0] {
    SRC_DL  = 2'd0,
    SRC_VID = 2'd1,
    SRC_CPU = 2'd2
  } src_t;

  // Bit positions inside the sticky err vector.
  localparam int unsigned ERR_TIMEOUT = 0;
  localparam int unsigned ERR_OVERRUN = 1;

endpackage

// File: rtl/x1_cpu_mem_arbiter_watchdog.sv
// Ack watchdog: counts access cycles without mem_ack and pulses expire
// in the ACK_TIMEOUT-th such cycle.
module x1_ack_watchdog #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam logic [TO_W-1:0] LP_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] r_cnt;

  assign expire = run & (r_cnt == LP_LAST);

  // Cycle counter: cleared on each grant, advances while an access waits for its ack.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/x1_cpu_mem_arbiter.sv
// X1 main-RAM arbiter: shares the RAM port between download loader, video
// fetch and the Z80, stalling the CPU via its clock enable while its access
// is outstanding and holding it in reset during downloads.
module x1_cpu_mem_arbiter
  import x1_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cep_in,
  output logic              cpu_cep,
  output logic              cpu_reset_n,
  input  logic              cpu_mreq_n,
  input  logic              cpu_wr_n,
  input  logic [ADDR_W-1:0] cpu_a,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_di,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_ack,
  input  logic              dl_active,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        err
);

  state_t            r_state;
  state_t            w_state_nxt;
  src_t              r_last;
  src_t              w_grant_src;
  logic              w_grant;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic [7:0]        r_cpu_di;
  logic [7:0]        r_vid_data;
  logic              r_vid_ack;
  logic              r_cpu_reset_n;
  logic              r_cpu_served;
  logic              r_dl_pend;
  logic [ADDR_W-1:0] r_dl_addr;
  logic [7:0]        r_dl_data;
  logic              r_err_to;
  logic              r_err_ov;

  logic              w_cpu_pend;
  logic              w_cpu_req;
  logic              w_vid_req;
  logic              w_in_acc;
  logic              w_run;
  logic              w_expire;
  logic              w_done;
  logic              w_dl_done;
  logic              w_vid_done;
  logic              w_cpu_done;
  logic [7:0]        w_rdata;

  assign w_cpu_pend = ~cpu_mreq_n & ~r_cpu_served;
  assign w_cpu_req  = w_cpu_pend & ~dl_active;
  // vid_req is still high in the cycle vid_ack is presented; masking it there
  // stops the same request being granted twice.
  assign w_vid_req  = vid_req & ~r_vid_ack;
  assign w_in_acc   = (r_state != IDLE);
  assign w_run      = w_in_acc & ~mem_ack;
  assign w_done     = w_in_acc & (mem_ack | w_expire);
  assign w_dl_done  = w_done & (r_state == DL_ACC);
  assign w_vid_done = w_done & (r_state == VID_ACC);
  assign w_cpu_done = w_done & (r_state == CPU_ACC);
  // A timed-out access completes with all-ones data.
  assign w_rdata    = mem_ack ? mem_rdata : 8'hFF;

  assign cpu_cep     = cep_in & ~w_cpu_pend;
  assign cpu_reset_n = r_cpu_reset_n;
  assign cpu_di      = r_cpu_di;
  assign vid_data    = r_vid_data;
  assign vid_ack     = r_vid_ack;
  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;

  // Assemble the sticky error flags at their named bit positions.
  always_comb begin
    err              = '0;
    err[ERR_TIMEOUT] = r_err_to;
    err[ERR_OVERRUN] = r_err_ov;
  end

  x1_ack_watchdog #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_grant),
    .run     (w_run),
    .expire  (w_expire)
  );

  // Next-state and grant selection: download first, then video/CPU with CPU favoured after a video grant.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_src = r_last;
    unique case (r_state)
      IDLE: begin
        if (r_dl_pend) begin
          w_grant     = 1'b1;
          w_grant_src = SRC_DL;
          w_state_nxt = DL_ACC;
        end else if (w_vid_req && !(w_cpu_req && (r_last == SRC_VID))) begin
          w_grant     = 1'b1;
          w_grant_src = SRC_VID;
          w_state_nxt = VID_ACC;
        end else if (w_cpu_req) begin
          w_grant     = 1'b1;
          w_grant_src = SRC_CPU;
          w_state_nxt = CPU_ACC;
        end
      end
      default: begin
        if (w_done) begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM request, read-data return and timeout flag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_di    <= 8'hFF;
      r_vid_data  <= '0;
      r_vid_ack   <= 1'b0;
      r_last      <= SRC_CPU;
      r_err_to    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_mem_req <= 1'b1;
        r_last    <= w_grant_src;
        unique case (w_grant_src)
          SRC_DL: begin
            r_mem_addr  <= r_dl_addr;
            r_mem_wdata <= r_dl_data;
            r_mem_we    <= 1'b1;
          end
          SRC_VID: begin
            r_mem_addr <= vid_addr;
            r_mem_we   <= 1'b0;
          end
          default: begin
            r_mem_addr  <= cpu_a;
            r_mem_wdata <= cpu_dout;
            r_mem_we    <= ~cpu_wr_n;
          end
        endcase
      end else if (w_done) begin
        r_mem_req <= 1'b0;
      end
      r_vid_ack <= w_vid_done;
      if (w_vid_done) begin
        r_vid_data <= w_rdata;
      end
      if (w_cpu_done && !r_mem_we) begin
        r_cpu_di <= w_rdata;
      end
      if (w_expire) begin
        r_err_to <= 1'b1;
      end
    end
  end

  // CPU served flag: set on completion, cleared once mreq_n is seen high.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cpu_served <= 1'b0;
    end else if (w_cpu_done) begin
      r_cpu_served <= 1'b1;
    end else if (cpu_mreq_n) begin
      r_cpu_served <= 1'b0;
    end
  end

  // Download holding register; a write landing on the ack cycle reloads without overrun.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_dl_pend <= 1'b0;
      r_dl_addr <= '0;
      r_dl_data <= '0;
      r_err_ov  <= 1'b0;
    end else if (dl_wr) begin
      r_dl_pend <= 1'b1;
      r_dl_addr <= dl_addr;
      r_dl_data <= dl_data;
      if (r_dl_pend && !w_dl_done) begin
        r_err_ov <= 1'b1;
      end
    end else if (w_dl_done) begin
      r_dl_pend <= 1'b0;
    end
  end

  // CPU reset follows the download state one cycle late.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cpu_reset_n <= 1'b0;
    end else begin
      r_cpu_reset_n <= ~dl_active;
    end
  end

endmodule

// File: doc/x1_cpu_mem_arbiter.md
Name: x1_cpu_mem_arbiter

Overview:
- Shares the single main-RAM port between three requesters: the HPS download loader, the video fetch unit, and the Z80 CPU wrapper (tv80e).
- Stalls the CPU by gating its clock enable until its memory cycle completes. The CPU's wait_n stays tied high.
- Holds the CPU in reset while a download is active.
- Sits between the cpu wrapper, the video block and the SDRAM/BRAM controller in the X1 top level.

Parameters:
- ADDR_W, 16, memory address width.
- ACK_TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting an access.
- TO_W, 8, width of the timeout counter. Must satisfy ACK_TIMEOUT < 2**TO_W.

Ports:
- clock, in, 1: system clock.
- reset_n, in, 1: reset, synchronous, active-low.
- cep_in, in, 1: raw CPU clock-enable pulse.
- cpu_cep, out, 1: gated clock enable to the cpu wrapper.
- cpu_reset_n, out, 1: reset to the cpu wrapper.
- cpu_mreq_n, in, 1: CPU memory request, active-low.
- cpu_wr_n, in, 1: CPU write strobe, active-low.
- cpu_a, in, ADDR_W: CPU address.
- cpu_dout, in, 8: CPU write data.
- cpu_di, out, 8: read data to CPU.
- vid_req, in, 1: video fetch request (level, held until vid_ack).
- vid_addr, in, ADDR_W: video fetch address.
- vid_data, out, 8: video read data.
- vid_ack, out, 1: one-cycle pulse; vid_data is valid in that cycle.
- dl_active, in, 1: download in progress.
- dl_wr, in, 1: one-cycle download write strobe.
- dl_addr, in, ADDR_W: download address.
- dl_data, in, 8: download data.
- mem_req, out, 1: RAM request.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, ADDR_W: RAM address.
- mem_wdata, out, 8: RAM write data.
- mem_rdata, in, 8: RAM read data.
- mem_ack, in, 1: one-cycle completion pulse from RAM.
- err, out, 2: sticky error flags. [0] = ack timeout, [1] = download overrun.

Behaviour:
- Reset (reset_n low at a clock edge):
  - State goes to IDLE.
  - mem_req, mem_we, vid_ack and err all go to 0.
  - mem_addr and mem_wdata go to 0.
  - cpu_di goes to 8'hFF; vid_data goes to 0.
  - cpu_reset_n goes to 0.
  - All pending flags and the download holding register are cleared.
  - Reset mid-access abandons the access; no ack is consumed afterwards.
- cpu_reset_n is registered. It equals ~dl_active one cycle later.
- CPU request: pending when cpu_mreq_n=0 and cpu_served=0.
  - cpu_served sets on completion.
  - cpu_served clears the cycle after cpu_mreq_n is seen high.
- cpu_cep = cep_in & ~(cpu_mreq_n==0 & ~cpu_served). This is combinational from registered state and the inputs. The CPU freezes while its access is outstanding.
- Download holding register:
  - dl_wr loads {dl_addr, dl_data} and sets dl_pend.
  - dl_wr while dl_pend=1 overwrites the held entry and sets err[1].
- States: IDLE, DL_ACC, VID_ACC, CPU_ACC.
- IDLE arbitration priority: dl_pend > vid_req > cpu pending.
  - Fairness: if the last grant was VID and CPU is pending, CPU beats VID.
  - Granting registers mem_addr/mem_we/mem_wdata and sets mem_req=1 on the same edge.
- mem_we per grant:
  - DL: mem_we=1.
  - VID: mem_we=0.
  - CPU: mem_we=~cpu_wr_n, sampled at grant.
- While in an ACC state, mem_req and the address/data/we are held stable until mem_ack.
- On mem_ack:
  - mem_req goes to 0 on the next edge and the state returns to IDLE.
  - There is at least one IDLE cycle between grants.
  - DL: clear dl_pend.
  - VID: vid_data<=mem_rdata, vid_ack=1 for one cycle.
  - CPU read: cpu_di<=mem_rdata. CPU (read or write): cpu_served<=1.
- Timeout:
  - The counter clears on grant and increments each ACC cycle without ack.
  - At ACK_TIMEOUT: set err[0], mem_req goes to 0, and the state returns to IDLE. The access completes as if acked with data 8'hFF, so the CPU and video never hang.
  - A late mem_ack arriving in IDLE is ignored.
- Simultaneous events:
  - A new request arriving in the ack cycle is arbitrated in the following IDLE cycle.
  - dl_wr in the same cycle as DL ack clears then reloads the register: dl_pend stays 1 and no overrun is flagged.
- dl_active=1 blocks CPU grants. The CPU is also held in reset.
- err is cleared only by reset.

Decomposition:
- Package x1_mem_pkg holds:
  - the state enum (IDLE, DL_ACC, VID_ACC, CPU_ACC);
  - the grant-source enum (SRC_DL, SRC_VID, SRC_CPU) used for the last-grant fairness register;
  - the err bit index constants.
- One sub-module, x1_ack_watchdog: the timeout counter. Inputs: clear, run. Output: expire pulse. Parameters: ACK_TIMEOUT, TO_W.

Test Plan:
1. CPU read at 16'h1234, RAM acks after 3 cycles with 8'h5A:
   - mem_req is high for 3 cycles with mem_we=0.
   - cpu_cep is 0 throughout.
   - cpu_di=8'h5A.
   - cpu_cep resumes the cycle after ack.
2. CPU write 8'hC3 to 16'h8000:
   - mem_we=1, mem_wdata=8'hC3.
   - cpu_di stays 8'hFF.
   - cpu_served clears after cpu_mreq_n rises.
3. vid_req and CPU pending together with immediate acks:
   - Grant order is VID, CPU, VID, CPU.
   - One IDLE cycle between each grant.
4. dl_active=1 with dl_wr bursts to 16'h0000..16'h0003:
   - Four writes in order.
   - cpu_reset_n=0.
   - dl_wr during a pending entry sets err[1].
5. CPU read with mem_ack never asserted:
   - After 255 cycles, err[0]=1 and cpu_di=8'hFF.
   - The CPU resumes; a late ack is ignored.
6. reset_n low during VID_ACC:
   - Next edge: mem_req=0, state IDLE, vid_ack=0.
   - No vid_ack is generated from the abandoned access.
